// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, flush and optional
// 2-entry skid buffer (registered in_ready) for GPR and HI/LO writeback.
module ex_mem_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
  } payload_t;

  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   in_payload;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;
  logic [1:0] occ_q, occ_d;
  logic       push, pop;

  // Skid build: in_ready comes from a flop tracking !skid_valid; flush still masks it.
  assign in_ready = ((SKID != 0) ? in_ready_q : (!main_valid_q || out_ready)) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    in_payload.wd    = ex_wd;
    in_payload.wreg  = ex_wreg;
    in_payload.wdata = ex_wdata;
    in_payload.whilo = ex_whilo;
    in_payload.hi    = ex_hi;
    in_payload.lo    = ex_lo;
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d = in_payload;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q) begin
        main_d       = in_payload;
        main_valid_d = 1'b1;
      end else if (SKID != 0) begin
        skid_d       = in_payload;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end

  // Bubbles present an all-zero payload so they can never write GPR or HI/LO.
  assign out_valid = main_valid_q;
  assign mem_wd    = main_valid_q ? main_q.wd    : '0;
  assign mem_wreg  = main_valid_q & main_q.wreg;
  assign mem_wdata = main_valid_q ? main_q.wdata : '0;
  assign mem_whilo = main_valid_q & main_q.whilo;
  assign mem_hi    = main_valid_q ? main_q.hi    : '0;
  assign mem_lo    = main_valid_q ? main_q.lo    : '0;
  assign occupancy = occ_q;

  a_no_ready_when_full: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && occupancy == 2'd2));
  a_no_write_on_bubble: assert property (@(posedge clk) disable iff (rst)
    !(!out_valid && (mem_wreg || mem_whilo)));

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: SKID=1 and SKID=0 instances share stimulus and are
// each checked every cycle against a queue model, plus directed literal checks.
module tb_ex_mem_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic [AW-1:0] ex_wd;
  logic          ex_wreg, ex_whilo;
  logic [DW-1:0] ex_wdata, ex_hi, ex_lo;

  logic          a_in_ready, a_out_valid, a_mem_wreg, a_mem_whilo;
  logic [AW-1:0] a_mem_wd;
  logic [DW-1:0] a_mem_wdata, a_mem_hi, a_mem_lo;
  logic [1:0]    a_occ;
  logic          b_in_ready, b_out_valid, b_mem_wreg, b_mem_whilo;
  logic [AW-1:0] b_mem_wd;
  logic [DW-1:0] b_mem_wdata, b_mem_hi, b_mem_lo;
  logic [1:0]    b_occ;

  ex_mem_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .out_valid(a_out_valid), .out_ready(out_ready),
    .mem_wd(a_mem_wd), .mem_wreg(a_mem_wreg), .mem_wdata(a_mem_wdata),
    .mem_whilo(a_mem_whilo), .mem_hi(a_mem_hi), .mem_lo(a_mem_lo), .occupancy(a_occ));

  ex_mem_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .out_valid(b_out_valid), .out_ready(out_ready),
    .mem_wd(b_mem_wd), .mem_wreg(b_mem_wreg), .mem_wdata(b_mem_wdata),
    .mem_whilo(b_mem_whilo), .mem_hi(b_mem_hi), .mem_lo(b_mem_lo), .occupancy(b_occ));

  typedef struct packed {
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } pl_t;

  pl_t qa[$];
  pl_t qb[$];
  int  n_pass  = 0;
  int  n_total = 0;
  bit  live    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp(input string tag, input logic ir, input logic ov,
                     input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
                     input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                     input logic [1:0] occ, input bit e_ir, input int e_n, input pl_t e_h);
    chk({tag, ".in_ready"},  64'(ir),    64'(e_ir));
    chk({tag, ".out_valid"}, 64'(ov),    64'(e_n > 0));
    chk({tag, ".mem_wd"},    64'(wd),    64'(e_h.wd));
    chk({tag, ".mem_wreg"},  64'(wreg),  64'(e_h.wreg));
    chk({tag, ".mem_wdata"}, 64'(wdata), 64'(e_h.wdata));
    chk({tag, ".mem_whilo"}, 64'(whilo), 64'(e_h.whilo));
    chk({tag, ".mem_hi"},    64'(hi),    64'(e_h.hi));
    chk({tag, ".mem_lo"},    64'(lo),    64'(e_h.lo));
    chk({tag, ".occupancy"}, 64'(occ),   64'(e_n));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    pl_t ha, hb, cur;
    bit  ira, irb;
    #1;
    ira = (qa.size() < 2) && !flush;
    irb = (qb.size() == 0 || out_ready) && !flush;
    ha  = (qa.size() > 0) ? qa[0] : '0;
    hb  = (qb.size() > 0) ? qb[0] : '0;
    if (live) begin
      cmp("skid1", a_in_ready, a_out_valid, a_mem_wd, a_mem_wreg, a_mem_wdata,
          a_mem_whilo, a_mem_hi, a_mem_lo, a_occ, ira, qa.size(), ha);
      cmp("skid0", b_in_ready, b_out_valid, b_mem_wd, b_mem_wreg, b_mem_wdata,
          b_mem_whilo, b_mem_hi, b_mem_lo, b_occ, irb, qb.size(), hb);
    end
    cur.wd = ex_wd; cur.wreg = ex_wreg; cur.wdata = ex_wdata;
    cur.whilo = ex_whilo; cur.hi = ex_hi; cur.lo = ex_lo;
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete(); live = 1'b1;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      if (qa.size() > 0 && out_ready) void'(qa.pop_front());
      if (in_valid && ira) qa.push_back(cur);
      if (qb.size() > 0 && out_ready) void'(qb.pop_front());
      if (in_valid && irb) qb.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic set_pl(input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
                        input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_pl('0, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset.occ", 64'(a_occ), 64'd0);
    chk("reset.out_valid", 64'(a_out_valid), 64'd0);
    chk("reset.mem_wdata", 64'(a_mem_wdata), 64'd0);
    chk("reset.in_ready", 64'(a_in_ready), 64'd1);

    // Reset then stream at full throughput
    in_valid = 1'b1; out_ready = 1'b1;
    set_pl(5'd5, 1'b1, 32'h1234, 1'b0, '0, '0);
    tick();
    chk("stream.out_valid", 64'(a_out_valid), 64'd1);
    chk("stream.mem_wd", 64'(a_mem_wd), 64'd5);
    chk("stream.mem_wdata", 64'(a_mem_wdata), 64'h1234);
    chk("stream.occ", 64'(a_occ), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      set_pl(5'd5, 1'b1, 32'h1234 + 32'(i), 1'b0, '0, '0);
      tick();
      chk("stream.tput", 64'(a_mem_wdata), 64'h1234 + 64'(i));
      chk("stream.tput_occ", 64'(a_occ), 64'd1);
    end
    in_valid = 1'b0;
    tick();

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    set_pl(5'd1, 1'b0, 32'hA, 1'b0, '0, '0);
    tick();
    set_pl(5'd2, 1'b0, 32'hB, 1'b0, '0, '0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp.occ", 64'(a_occ), 64'd2);
    chk("bp.in_ready", 64'(a_in_ready), 64'd0);
    chk("bp.head", 64'(a_mem_wdata), 64'hA);
    out_ready = 1'b1;
    tick();
    chk("bp.second", 64'(a_mem_wdata), 64'hB);
    tick();
    chk("bp.drained", 64'(a_occ), 64'd0);

    // Bubble gating after the only payload pops
    in_valid = 1'b1;
    set_pl(5'd7, 1'b1, 32'h55, 1'b1, 32'hFFFF0000, 32'h1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("bubble.out_valid", 64'(a_out_valid), 64'd0);
    chk("bubble.wreg", 64'(a_mem_wreg), 64'd0);
    chk("bubble.whilo", 64'(a_mem_whilo), 64'd0);
    chk("bubble.wd", 64'(a_mem_wd), 64'd0);
    chk("bubble.hi", 64'(a_mem_hi), 64'd0);
    chk("bubble.b_wreg", 64'(b_mem_wreg), 64'd0);

    // Flush while full, with a competing push of C
    out_ready = 1'b0; in_valid = 1'b1;
    set_pl(5'd3, 1'b1, 32'h1, 1'b0, '0, '0);
    tick();
    set_pl(5'd3, 1'b1, 32'h2, 1'b0, '0, '0);
    tick();
    flush = 1'b1;
    set_pl(5'd9, 1'b1, 32'hC, 1'b0, '0, '0);
    #1;
    chk("flush.in_ready", 64'(a_in_ready), 64'd0);
    chk("flush.b_in_ready", 64'(b_in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush.occ", 64'(a_occ), 64'd0);
    chk("flush.out_valid", 64'(a_out_valid), 64'd0);
    chk("flush.in_ready_after", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("flush.no_c", 64'(a_out_valid), 64'd0);

    // Single-entry build: in_ready follows out_ready while full
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_ready = (k % 2 == 0);
      set_pl(5'd4, 1'b1, 32'h100 + 32'(k), 1'b0, '0, '0);
      #1;
      if (b_occ == 2'd1) chk("skid0.mirror", 64'(b_in_ready), 64'(out_ready));
      chk("skid0.occ_max", 64'(b_occ <= 2'd1), 64'd1);
      tick();
    end

    // Reset mid-stall
    out_ready = 1'b0;
    set_pl(5'd6, 1'b1, 32'hDEAD, 1'b1, 32'h3, 32'h4);
    tick(); tick();
    chk("rststall.full", 64'(a_occ), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rststall.occ", 64'(a_occ), 64'd0);
    chk("rststall.out_valid", 64'(a_out_valid), 64'd0);
    chk("rststall.wdata", 64'(a_mem_wdata), 64'd0);
    chk("rststall.in_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("rststall.no_stale", 64'(a_out_valid), 64'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_pl(AW'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX->MEM pipeline stage register carrying GPR writeback (wd/wreg/wdata) and HI/LO writeback (whilo/hi/lo). It adds a valid/ready handshake, back-pressure, and flush, with an optional 2-entry skid buffer so that in_ready is registered. It sits between the execute stage and the memory stage and replaces the plain always-load stage register.

Parameters:
DATA_W, 32, width of wdata, hi and lo
REG_ADDR_W, 5, width of the destination register address
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  EX presents a valid payload
in_ready  out  1  stage can accept a payload this cycle
ex_wd  in  REG_ADDR_W  destination GPR address
ex_wreg  in  1  GPR write enable
ex_wdata  in  DATA_W  GPR write data
ex_whilo  in  1  HI/LO write enable
ex_hi  in  DATA_W  HI write data
ex_lo  in  DATA_W  LO write data
out_valid  out  1  MEM-side payload valid
out_ready  in  1  MEM consumes the payload this cycle
mem_wd  out  REG_ADDR_W  registered ex_wd
mem_wreg  out  1  registered ex_wreg, gated by out_valid
mem_wdata  out  DATA_W  registered ex_wdata
mem_whilo  out  1  registered ex_whilo, gated by out_valid
mem_hi  out  DATA_W  registered ex_hi
mem_lo  out  DATA_W  registered ex_lo
occupancy  out  2  number of valid entries held (0..2)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: both entry valids cleared, payload registers cleared, occupancy=0. out_valid=0 and all mem_* outputs=0. in_ready is 1 in the first cycle after reset unless flush is asserted.
- Accept: push = in_valid & in_ready. Pop = out_valid & out_ready.
- Payload gating: whenever out_valid=0, every mem_* output reads 0, including mem_wd (NOPRegAddr). A bubble can never write the GPR file or HI/LO.
- Latency: into an empty stage, a payload accepted at edge N appears on mem_* with out_valid=1 after edge N, i.e. 1 cycle.
- SKID=1 datapath: main entry drives the outputs; a skid entry holds the overflow.
  - in_ready = !skid_valid, driven from a register.
  - Push, main empty: load main.
  - Push and pop together, skid empty: main reloads from the input.
  - Push, main full, no pop: load skid.
  - Pop with skid valid: skid moves to main, skid empties. A push in the same cycle is impossible, because in_ready=0.
  - Pop, skid empty, no push: main empties.
- SKID=0 datapath: single entry. in_ready = !out_valid | out_ready, combinational. occupancy is 0 or 1.
- Order: strict FIFO order; no payload is duplicated or dropped except by flush or rst.
- Flush: priority is rst > flush > normal.
  - In the flush cycle, in_ready is forced to 0 combinationally, so there is no push.
  - On the edge, all valids are cleared.
  - The cycle after flush: occupancy=0, out_valid=0, and in_ready=1 if flush has deasserted.
  - A pop in the flush cycle is still a legal handshake; the entry is not re-presented afterwards.
- Stall: out_ready=0 holds main, and the skid entry if filled, indefinitely with stable mem_* values.
- Reset mid-operation: rst in any cycle clears all state on that edge regardless of in_valid, out_ready or flush.
- occupancy: registered, equal to main_valid + skid_valid.
- Assertions:
  - in_ready must never be 1 while occupancy=2.
  - mem_wreg and mem_whilo must never be 1 while out_valid=0.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with wd=5, wreg=1, wdata=0x1234, out_ready=1 -> next cycle out_valid=1, mem_wd=5, mem_wdata=0x1234, occupancy=1, and full throughput of 1 per cycle is sustained.
- Back-pressure (SKID=1): out_ready=0, push A (wdata=0xA), then B (0xB) -> occupancy=2, in_ready=0, outputs show A. Release out_ready -> A, then B, in consecutive cycles, then occupancy=0.
- Bubble gating: push one payload with wreg=1, whilo=1, hi=0xFFFF0000, then in_valid=0 -> after the pop, out_valid=0 and mem_wreg=0, mem_whilo=0, mem_wd=0, mem_hi=0.
- Flush while full: occupancy=2, flush=1 together with in_valid=1 (payload C) -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0, and C never appears.
- SKID=0 build: out_ready toggled 1,0,1 with continuous in_valid -> in_ready mirrors out_ready while full, no payload is lost, and occupancy never exceeds 1.
- Reset mid-stall: occupancy=2, out_ready=0, rst=1 for 1 cycle -> all outputs 0, in_ready=1 the next cycle, and no stale payload emerges.
